// File: rtl/gcode2bin_stream.sv
// Gray-to-binary decoder with a 2-entry valid/ready output FIFO carrying a per-word error bit.
// Optional macro GCODE2BIN_STREAM_ADJ_CHECK_EN adds a Gray adjacency checker on accepted words.
module gcode2bin_stream #(
  parameter int NBITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_val,
  output logic             in_rdy,
  input  logic [NBITS-1:0] in_,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [NBITS-1:0] out,
  output logic             err
);

  logic [NBITS-1:0] bin_word;
  logic             err_in;

  // Each binary bit is the XOR of all Gray bits at or above it.
  genvar gi;
  generate
    for (gi = 0; gi < NBITS; gi++) begin : g_dec
      assign bin_word[gi] = ^in_[NBITS-1:gi];
    end
  endgenerate

  logic [1:0][NBITS:0] mem_q, mem_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [1:0]          count_q, count_d;
  logic                en_q, en_d;
  logic [NBITS-1:0]    out_last_q, out_last_d;
  logic [NBITS:0]      head;
  logic                push, pop;

  assign head    = mem_q[rd_ptr_q];
  assign out_val = (count_q != 2'd0);
  // en_q keeps in_rdy low until the first edge after reset release.
  assign in_rdy  = en_q && (count_q != 2'd2);
  assign push    = in_val && in_rdy;
  assign pop     = out_val && out_rdy;
  assign out     = out_val ? head[NBITS-1:0] : out_last_q;
  assign err     = out_val && head[NBITS];

`ifdef GCODE2BIN_STREAM_ADJ_CHECK_EN
  logic [NBITS-1:0] prev_q, prev_d;
  logic             have_prev_q, have_prev_d;

  always_comb begin
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    err_in      = have_prev_q && ($countones(in_ ^ prev_q) != 1);
    if (push) begin
      prev_d      = in_;
      have_prev_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev_q      <= '0;
      have_prev_q <= 1'b0;
    end else begin
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
    end
  end
`else
  assign err_in = 1'b0;
`endif

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    en_d       = 1'b1;
    out_last_d = out_val ? head[NBITS-1:0] : out_last_q;
    if (push) begin
      mem_d[wr_ptr_q] = {err_in, bin_word};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    if (push && !pop) begin
      count_d = count_q + 2'd1;
    end else if (pop && !push) begin
      count_d = count_q - 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q      <= '0;
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      en_q       <= 1'b0;
      out_last_q <= '0;
    end else begin
      mem_q      <= mem_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      en_q       <= en_d;
      out_last_q <= out_last_d;
    end
  end

endmodule

// File: tb/tb_gcode2bin_stream.sv
// Randomized and directed bench for gcode2bin_stream against a queue-based reference model.
module tb_gcode2bin_stream;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_val = 1'b0;
  logic         in_rdy;
  logic [N-1:0] in_ = '0;
  logic         out_val;
  logic         out_rdy = 1'b0;
  logic [N-1:0] out;
  logic         err;

  int n_checks = 0;
  int n_fail   = 0;

  gcode2bin_stream #(.NBITS(N)) dut (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy), .in_(in_),
    .out_val(out_val), .out_rdy(out_rdy), .out(out), .err(err)
  );

  always #5 clk = ~clk;

  // Reference model: queue entries are {err, binary}.
  logic [N:0]   mq[$];
  bit           m_en;
  bit           m_have_prev;
  logic [N-1:0] m_prev;
  logic [N-1:0] m_last;

`ifdef GCODE2BIN_STREAM_ADJ_CHECK_EN
  localparam bit ADJ = 1'b1;
`else
  localparam bit ADJ = 1'b0;
`endif

  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b = g;
    for (int k = 1; k < N; k++) b = b ^ (g >> k);
    return b;
  endfunction

  function automatic int hamming(input logic [N-1:0] a, input logic [N-1:0] b);
    int c = 0;
    for (int k = 0; k < N; k++) if (a[k] != b[k]) c++;
    return c;
  endfunction

  function automatic logic [N-1:0] exp_out();
    return (mq.size() > 0) ? mq[0][N-1:0] : m_last;
  endfunction

  function automatic logic exp_err();
    return (mq.size() > 0) ? mq[0][N] : 1'b0;
  endfunction

  function automatic logic exp_rdy();
    return m_en && (mq.size() < 2);
  endfunction

  task automatic model_reset();
    mq.delete();
    m_en = 0; m_have_prev = 0; m_prev = '0; m_last = '0;
  endtask

  task automatic model_step(input logic v, input logic [N-1:0] d, input logic r);
    bit do_push, do_pop;
    logic e;
    do_push = v && m_en && (mq.size() < 2);
    do_pop  = r && (mq.size() > 0);
    if (mq.size() > 0) m_last = mq[0][N-1:0];
    if (do_pop) begin
      $display("pop  bin=%b err=%b", mq[0][N-1:0], mq[0][N]);
      void'(mq.pop_front());
    end
    if (do_push) begin
      e = ADJ && m_have_prev && (hamming(d, m_prev) != 1);
      m_prev = d; m_have_prev = 1;
      mq.push_back({e, gray2bin(d)});
      $display("push gray=%b bin=%b err=%b", d, gray2bin(d), e);
    end
    m_en = 1;
  endtask

  // One clock: drive, advance DUT and model together, settle 1 time unit past the edge.
  task automatic tick(input logic v, input logic [N-1:0] d, input logic r);
    in_val = v; in_ = d; out_rdy = r;
    @(posedge clk);
    model_step(v, d, r);
    #1;
  endtask

  task automatic apply_reset();
    in_val = 0; out_rdy = 0;
    reset = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 reset = 1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b0 || out !== '0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: got val=%b rdy=%b out=%b err=%b, want 0 0 0000 0", out_val, in_rdy, out, err);
    end
    apply_reset();
    n_checks++;
    if (in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rdy_before_edge: got %b want 0", in_rdy);
    end
    tick(0, '0, 0);
    n_checks++;
    if (in_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_after_edge: got %b want 1", in_rdy);
    end
  endtask

  task automatic test_decode();
    logic [N-1:0] g[5] = '{4'b0000, 4'b0001, 4'b0110, 4'b1100, 4'b1000};
    logic [N-1:0] b[5] = '{4'b0000, 4'b0001, 4'b0100, 4'b1000, 4'b1111};
    apply_reset();
    tick(0, '0, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1, g[i], 1);
      n_checks++;
      if (out_val !== 1'b1 || out !== b[i]) begin
        n_fail++;
        $display("FAIL decode_%0d: got val=%b out=%b, want 1 %b", i, out_val, out, b[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [N-1:0] want[3] = '{4'b0001, 4'b0010, 4'b0011};
    apply_reset();
    tick(0, '0, 0);
    tick(1, 4'b0001, 0);
    tick(1, 4'b0011, 0);
    n_checks++;
    if (in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full_rdy: got %b want 0", in_rdy);
    end
    tick(1, 4'b0010, 1);
    n_checks++;
    if (out !== want[1]) begin
      n_fail++;
      $display("FAIL bp_full_no_bypass: got out=%b want %b", out, want[1]);
    end
    tick(1, 4'b0010, 1);
    n_checks++;
    if (out !== want[2] || out_val !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_order_last: got val=%b out=%b want 1 %b", out_val, out, want[2]);
    end
    tick(0, '0, 1);
    n_checks++;
    if (out_val !== 1'b0 || out !== want[2] || err !== 1'b0) begin
      n_fail++;
      $display("FAIL empty_hold: got val=%b out=%b err=%b want 0 %b 0", out_val, out, err, want[2]);
    end
  endtask

  task automatic test_backpressure_hold();
    apply_reset();
    tick(0, '0, 0);
    tick(1, 4'b0001, 0);
    n_checks++;
    if (out !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_head_first: got %b want 0001", out);
    end
    tick(1, 4'b0011, 0);
    tick(1, 4'b0010, 0);
    n_checks++;
    if (out !== 4'b0001 || in_rdy !== 1'b0 || out_val !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_hold: got out=%b rdy=%b val=%b want 0001 0 1", out, in_rdy, out_val);
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] g;
    apply_reset();
    tick(0, '0, 0);
    tick(1, '0, 0);
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (out_val !== 1'b1 || in_rdy !== 1'b1 || out !== N'(i - 1)) begin
        n_fail++;
        $display("FAIL b2b_%0d: got val=%b rdy=%b out=%0d want 1 1 %0d", i, out_val, in_rdy, out, i - 1);
      end
      g = N'(i ^ (i >> 1));
      tick(1, g, 1);
    end
  endtask

  task automatic test_adjacency();
    logic [N-1:0] g[4] = '{4'b0000, 4'b0001, 4'b0111, 4'b0111};
    logic         e[4] = '{1'b0, 1'b0, ADJ, ADJ};
    apply_reset();
    tick(0, '0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(1, g[i], 1);
      n_checks++;
      if (err !== e[i]) begin
        n_fail++;
        $display("FAIL adj_%0d: got err=%b want %b", i, err, e[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    apply_reset();
    tick(0, '0, 0);
    tick(1, 4'b0101, 0);
    tick(1, 4'b0110, 0);
    #2 reset = 0;
    model_reset();
    #1;
    n_checks++;
    if (out_val !== 1'b0 || in_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_async: got val=%b rdy=%b want 0 0", out_val, in_rdy);
    end
    @(posedge clk);
    #1 reset = 1;
    tick(0, '0, 0);
    tick(1, 4'b0011, 0);
    n_checks++;
    if (out_val !== 1'b1 || out !== 4'b0010 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_first: got val=%b out=%b err=%b want 1 0010 0", out_val, out, err);
    end
    tick(0, '0, 1);
    n_checks++;
    if (out_val !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_stale: got val=%b want 0", out_val);
    end
  endtask

  task automatic test_random();
    logic         v, r;
    logic [N-1:0] d;
    apply_reset();
    for (int c = 0; c < 300; c++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 2) != 0);
      // Half the time offer a Gray neighbour of the last word so the checker sees both outcomes.
      d = ($urandom_range(0, 1) == 1) ? (m_prev ^ N'(1 << $urandom_range(0, N - 1))) : N'($urandom);
      tick(v, d, r);
      n_checks++;
      if (in_rdy !== exp_rdy() || out_val !== (mq.size() > 0) ||
          out !== exp_out() || err !== exp_err()) begin
        n_fail++;
        $display("FAIL random_%0d: got rdy=%b val=%b out=%b err=%b want %b %b %b %b", c,
                 in_rdy, out_val, out, err, exp_rdy(), (mq.size() > 0), exp_out(), exp_err());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_decode();
    test_backpressure();
    test_backpressure_hold();
    test_back_to_back();
    test_adjacency();
    test_mid_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
